// File: rtl/alu_datapath_seq_pkg.sv
// rtl/alu_datapath_seq_pkg.sv - shared opcodes, FSM states and flag indices
// Contents: OP_* opcode constants, state_t sequencer states, FLAG_* bit
// positions within the 4-bit {N,V,C,Z} flag vector.
package alu_seq_pkg;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_NOT = 3'b101;
    localparam logic [2:0] OP_SHL = 3'b110;
    localparam logic [2:0] OP_SHR = 3'b111;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        EXEC  = 2'd2,
        WRITE = 2'd3
    } state_t;

    localparam int FLAG_Z = 0;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 2;
    localparam int FLAG_N = 3;

endpackage

// File: rtl/alu_datapath_seq_if.sv
// rtl/alu_datapath_seq_if.sv - bus, load and command signals of the ALU datapath
// master: control-unit side (drives bus_in, loads, commands, out_en)
// slave : datapath side (drives cmd_ready, bus_out, bus_oe, done, flags)
interface alu_datapath_seq_if #(
    parameter int WIDTH = 16,
    parameter int NREGS = 4
);
    localparam int AW = $clog2(NREGS);

    logic [WIDTH-1:0] bus_in;
    logic             ld_en;
    logic [AW-1:0]    ld_addr;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [2:0]       cmd_op;
    logic [AW-1:0]    cmd_src_a;
    logic [AW-1:0]    cmd_src_b;
    logic [AW-1:0]    cmd_dst;
    logic             out_en;
    logic [WIDTH-1:0] bus_out;
    logic             bus_oe;
    logic             done;
    logic [3:0]       flags;

    modport master (
        output bus_in, ld_en, ld_addr,
        output cmd_valid, cmd_op, cmd_src_a, cmd_src_b, cmd_dst,
        output out_en,
        input  cmd_ready, bus_out, bus_oe, done, flags
    );

    modport slave (
        input  bus_in, ld_en, ld_addr,
        input  cmd_valid, cmd_op, cmd_src_a, cmd_src_b, cmd_dst,
        input  out_en,
        output cmd_ready, bus_out, bus_oe, done, flags
    );

endinterface

// File: rtl/alu_datapath_seq_alu_core.sv
// rtl/alu_datapath_seq_alu_core.sv - combinational ALU with {N,V,C,Z} flags
// Ports: a, b (WIDTH operands), op (3-bit opcode) -> res (WIDTH), flags (4)
module alu_core
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    output logic [WIDTH-1:0] res,
    output logic [3:0]       flags
);

    // One extra bit holds carry-out for ADD and borrow for SUB.
    logic [WIDTH:0] sum;
    logic           c;
    logic           v;

    always_comb begin
        sum = '0;
        res = '0;
        c   = 1'b0;
        v   = 1'b0;
        case (op)
            OP_ADD: begin
                sum = {1'b0, a} + {1'b0, b};
                res = sum[WIDTH-1:0];
                c   = sum[WIDTH];
                v   = (a[WIDTH-1] == b[WIDTH-1]) && (res[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                // The top bit of the widened difference is set exactly when a < b.
                sum = {1'b0, a} - {1'b0, b};
                res = sum[WIDTH-1:0];
                c   = sum[WIDTH];
                v   = (a[WIDTH-1] != b[WIDTH-1]) && (res[WIDTH-1] != a[WIDTH-1]);
            end
            OP_AND: res = a & b;
            OP_OR:  res = a | b;
            OP_XOR: res = a ^ b;
            OP_NOT: res = ~a;
            OP_SHL: begin
                res = {a[WIDTH-2:0], 1'b0};
                c   = a[WIDTH-1];
            end
            OP_SHR: begin
                res = {1'b0, a[WIDTH-1:1]};
                c   = a[0];
            end
            default: res = '0;
        endcase

        flags         = 4'b0000;
        flags[FLAG_N] = res[WIDTH-1];
        flags[FLAG_V] = v;
        flags[FLAG_C] = c;
        flags[FLAG_Z] = (res == '0);
    end

endmodule

// File: rtl/alu_datapath_seq.sv
// rtl/alu_datapath_seq.sv - register file plus command-driven fetch/exec/write sequencer
// Ports: clk, rst (sync, active-high), io (alu_datapath_seq_if.slave):
//   bus_in/ld_en/ld_addr load a register while idle; cmd_* valid/ready command
//   handshake; out_en gates result_reg onto bus_out; done pulses after write-back;
//   flags holds {N,V,C,Z} of the last completed operation.
module alu_datapath_seq
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int NREGS = 4
) (
    input  logic              clk,
    input  logic              rst,
    alu_datapath_seq_if.slave io
);

    localparam int AW = $clog2(NREGS);

    state_t           state;
    state_t           state_nxt;
    logic             cmd_ready;

    logic [WIDTH-1:0] regs [NREGS];

    logic [2:0]       op_q;
    logic [AW-1:0]    src_a_q;
    logic [AW-1:0]    src_b_q;
    logic [AW-1:0]    dst_q;

    logic [WIDTH-1:0] opa_q;
    logic [WIDTH-1:0] opb_q;
    logic [WIDTH-1:0] res_q;
    logic [3:0]       res_flags_q;

    logic [WIDTH-1:0] result_reg;
    logic [3:0]       flags_q;
    logic             done_q;

    logic [WIDTH-1:0] alu_res;
    logic [3:0]       alu_flags;

    alu_core #(.WIDTH(WIDTH)) u_alu (
        .a     (opa_q),
        .b     (opb_q),
        .op    (op_q),
        .res   (alu_res),
        .flags (alu_flags)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cmd_ready = 1'b0;
        case (state)
            IDLE: begin
                cmd_ready = 1'b1;
                if (io.cmd_valid) begin
                    state_nxt = FETCH;
                end
            end
            FETCH:   state_nxt = EXEC;
            EXEC:    state_nxt = WRITE;
            WRITE:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Loads are only honoured while idle, so they can never collide with the
    // write-back port. Operands are copied in FETCH, which makes src==dst safe.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
            op_q        <= '0;
            src_a_q     <= '0;
            src_b_q     <= '0;
            dst_q       <= '0;
            opa_q       <= '0;
            opb_q       <= '0;
            res_q       <= '0;
            res_flags_q <= '0;
            result_reg  <= '0;
            flags_q     <= '0;
            done_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (io.ld_en) begin
                        regs[io.ld_addr] <= io.bus_in;
                    end
                    if (io.cmd_valid) begin
                        op_q    <= io.cmd_op;
                        src_a_q <= io.cmd_src_a;
                        src_b_q <= io.cmd_src_b;
                        dst_q   <= io.cmd_dst;
                    end
                end
                FETCH: begin
                    opa_q <= regs[src_a_q];
                    opb_q <= regs[src_b_q];
                end
                EXEC: begin
                    res_q       <= alu_res;
                    res_flags_q <= alu_flags;
                end
                WRITE: begin
                    regs[dst_q] <= res_q;
                    result_reg  <= res_q;
                    flags_q     <= res_flags_q;
                    done_q      <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign io.cmd_ready = cmd_ready;
    assign io.bus_out   = io.out_en ? result_reg : '0;
    assign io.bus_oe    = io.out_en;
    assign io.done      = done_q;
    assign io.flags     = flags_q;

endmodule

// File: tb/tb_alu_datapath_seq.sv
// tb/tb_alu_datapath_seq.sv - directed bench for alu_datapath_seq at 16x4 and 8x8
module tb_alu_datapath_seq;
    import alu_seq_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   vectors = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;

    alu_datapath_seq_if #(.WIDTH(16), .NREGS(4)) io16 ();
    alu_datapath_seq_if #(.WIDTH(8),  .NREGS(8)) io8 ();

    alu_datapath_seq #(.WIDTH(16), .NREGS(4)) dut16 (
        .clk (clk),
        .rst (rst),
        .io  (io16)
    );

    alu_datapath_seq #(.WIDTH(8), .NREGS(8)) dut8 (
        .clk (clk),
        .rst (rst),
        .io  (io8)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic load16(input logic [1:0] a, input logic [15:0] v);
        io16.ld_en   = 1'b1;
        io16.ld_addr = a;
        io16.bus_in  = v;
        step();
        io16.ld_en   = 1'b0;
    endtask

    task automatic issue16(input logic [2:0] op, input logic [1:0] a, input logic [1:0] b, input logic [1:0] d);
        int n = 0;
        io16.cmd_op    = op;
        io16.cmd_src_a = a;
        io16.cmd_src_b = b;
        io16.cmd_dst   = d;
        io16.cmd_valid = 1'b1;
        while (io16.cmd_ready !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        if (n >= 20) chk("ready_timeout16", 32'(n), 32'd0);
        step();
        io16.cmd_valid = 1'b0;
    endtask

    task automatic wait_done16(input string tag, input int exp);
        int n = 0;
        while (io16.done !== 1'b1 && n < 10) begin
            step();
            n++;
        end
        chk(tag, 32'(n), 32'(exp));
    endtask

    task automatic op16(input string tag, input logic [2:0] op, input logic [1:0] a, input logic [1:0] b,
                        input logic [1:0] d, input logic [15:0] exp_res, input logic [3:0] exp_flags);
        issue16(op, a, b, d);
        wait_done16({tag, "_lat"}, 3);
        chk({tag, "_res"}, 32'(io16.bus_out), 32'(exp_res));
        chk({tag, "_flags"}, 32'(io16.flags), 32'(exp_flags));
    endtask

    task automatic load8(input logic [2:0] a, input logic [7:0] v);
        io8.ld_en   = 1'b1;
        io8.ld_addr = a;
        io8.bus_in  = v;
        step();
        io8.ld_en   = 1'b0;
    endtask

    task automatic op8(input string tag, input logic [2:0] op, input logic [2:0] a, input logic [2:0] b,
                       input logic [2:0] d, input logic [7:0] exp_res, input logic [3:0] exp_flags);
        int n = 0;
        io8.cmd_op    = op;
        io8.cmd_src_a = a;
        io8.cmd_src_b = b;
        io8.cmd_dst   = d;
        io8.cmd_valid = 1'b1;
        while (io8.cmd_ready !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        if (n >= 20) chk("ready_timeout8", 32'(n), 32'd0);
        step();
        io8.cmd_valid = 1'b0;
        n = 0;
        while (io8.done !== 1'b1 && n < 10) begin
            step();
            n++;
        end
        chk({tag, "_lat"}, 32'(n), 32'd3);
        chk({tag, "_res"}, 32'(io8.bus_out), 32'(exp_res));
        chk({tag, "_flags"}, 32'(io8.flags), 32'(exp_flags));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        io16.bus_in = '0; io16.ld_en = 1'b0; io16.ld_addr = '0; io16.cmd_valid = 1'b0;
        io16.cmd_op = '0; io16.cmd_src_a = '0; io16.cmd_src_b = '0; io16.cmd_dst = '0;
        io16.out_en = 1'b1;
        io8.bus_in = '0; io8.ld_en = 1'b0; io8.ld_addr = '0; io8.cmd_valid = 1'b0;
        io8.cmd_op = '0; io8.cmd_src_a = '0; io8.cmd_src_b = '0; io8.cmd_dst = '0;
        io8.out_en = 1'b1;

        // Reset
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        chk("rst_bus_out", 32'(io16.bus_out), 32'h0);
        chk("rst_flags", 32'(io16.flags), 32'h0);
        chk("rst_ready", 32'(io16.cmd_ready), 32'h1);
        chk("rst_done", 32'(io16.done), 32'h0);
        chk("rst_oe", 32'(io16.bus_oe), 32'h1);

        // ADD with signed overflow
        load16(2'd0, 16'h7FFF);
        load16(2'd1, 16'h0001);
        op16("add_ovf", OP_ADD, 2'd0, 2'd1, 2'd2, 16'h8000, 4'b1100);
        step();
        chk("done_pulse", 32'(io16.done), 32'h0);
        io16.out_en = 1'b0;
        #1;
        chk("out_en0_bus", 32'(io16.bus_out), 32'h0);
        chk("out_en0_oe", 32'(io16.bus_oe), 32'h0);
        io16.out_en = 1'b1;
        op16("rd_r2", OP_OR, 2'd2, 2'd2, 2'd3, 16'h8000, 4'b1000);

        // SUB with borrow, then SUB to zero
        op16("sub_borrow", OP_SUB, 2'd1, 2'd0, 2'd1, 16'h8002, 4'b1010);
        load16(2'd3, 16'h0000);
        op16("sub_zero", OP_SUB, 2'd3, 2'd3, 2'd3, 16'h0000, 4'b0001);

        // Shifts, NOT and logic ops
        load16(2'd0, 16'h8001);
        op16("shl", OP_SHL, 2'd0, 2'd0, 2'd2, 16'h0002, 4'b0010);
        load16(2'd1, 16'h0001);
        op16("shr", OP_SHR, 2'd1, 2'd1, 2'd2, 16'h0000, 4'b0011);
        load16(2'd0, 16'h00FF);
        op16("not", OP_NOT, 2'd0, 2'd0, 2'd2, 16'hFF00, 4'b1000);
        op16("xor", OP_XOR, 2'd0, 2'd2, 2'd3, 16'hFFFF, 4'b1000);
        op16("and", OP_AND, 2'd0, 2'd2, 2'd3, 16'h0000, 4'b0001);

        // Load and command in the same idle cycle: FETCH sees the new value
        io16.ld_en   = 1'b1;
        io16.ld_addr = 2'd0;
        io16.bus_in  = 16'h0005;
        issue16(OP_ADD, 2'd0, 2'd0, 2'd1);
        io16.ld_en   = 1'b0;
        wait_done16("ld_cmd_lat", 3);
        chk("ld_cmd_res", 32'(io16.bus_out), 32'h000A);

        // Load during EXEC is dropped
        issue16(OP_ADD, 2'd1, 2'd1, 2'd2);
        step();
        io16.ld_en   = 1'b1;
        io16.ld_addr = 2'd1;
        io16.bus_in  = 16'hFFFF;
        step();
        io16.ld_en   = 1'b0;
        wait_done16("ld_exec_lat", 1);
        chk("ld_exec_res", 32'(io16.bus_out), 32'h0014);
        op16("ld_exec_keep", OP_OR, 2'd1, 2'd1, 2'd3, 16'h000A, 4'b0000);

        // Command held while busy is taken on the next idle cycle only
        issue16(OP_ADD, 2'd1, 2'd1, 2'd2);
        io16.cmd_op    = OP_OR;
        io16.cmd_src_a = 2'd1;
        io16.cmd_src_b = 2'd0;
        io16.cmd_dst   = 2'd3;
        io16.cmd_valid = 1'b1;
        chk("busy_ready", 32'(io16.cmd_ready), 32'h0);
        begin
            int n = 0;
            while (io16.cmd_ready !== 1'b1 && n < 10) begin
                step();
                n++;
            end
            chk("held_wait", 32'(n), 32'd3);
        end
        chk("held_first_done", 32'(io16.done), 32'h1);
        chk("held_first_res", 32'(io16.bus_out), 32'h0014);
        step();
        io16.cmd_valid = 1'b0;
        wait_done16("held_second_lat", 3);
        chk("held_second_res", 32'(io16.bus_out), 32'h000F);

        // Reset during EXEC aborts the operation
        issue16(OP_ADD, 2'd0, 2'd1, 2'd2);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("abort_ready", 32'(io16.cmd_ready), 32'h1);
        chk("abort_flags", 32'(io16.flags), 32'h0);
        for (int i = 0; i < 4; i++) begin
            chk("abort_no_done", 32'(io16.done), 32'h0);
            step();
        end
        op16("abort_dst", OP_OR, 2'd2, 2'd2, 2'd3, 16'h0000, 4'b0001);

        // Narrow instance: 8-bit wrap-around and overflow
        load8(3'd6, 8'hFF);
        load8(3'd7, 8'h01);
        op8("add8_wrap", OP_ADD, 3'd6, 3'd7, 3'd5, 8'h00, 4'b0011);
        load8(3'd6, 8'h7F);
        op8("add8_ovf", OP_ADD, 3'd6, 3'd7, 3'd4, 8'h80, 4'b1100);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
